// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct values, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;

  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU     = 2'd0;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd2;

  // First state after DECODE for a given opcode; R-type funct legality
  // is checked separately by the ALU-op decoder.
  function automatic state_e dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:      dispatch = S_R_EXEC;
      OP_LW, OP_SW:  dispatch = S_MEM_ADDR;
      OP_ADDI:       dispatch = S_I_EXEC;
      OP_BEQ, OP_BNE: dispatch = S_BRANCH;
      OP_J:          dispatch = S_JUMP;
      default:       dispatch = S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct to ALU operation decoder; flags unsupported funct codes.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // Pure lookup; unknown funct yields ADD with the illegal flag raised.
  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      FN_SLL:  alu_op_o = ALU_SLL;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Outputs are decoded from the current state;
// ir_write/pc_write in FETCH and pc_write in BRANCH additionally depend on
// mem_ready/zero in the same cycle.
//
// Memory handshake: the FSM holds a memory state (FETCH, MEM_READ,
// MEM_WRITE) with its strobe asserted until mem_ready is sampled high on a
// rising edge; that edge completes the access and advances the state.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic [3:0]  alu_op,
  output logic [3:0]  state,
  output logic        exception,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [5:0]  op_q;
  logic [5:0]  funct_q;
  logic [31:0] count_q;

  logic [5:0]  dec_funct;
  logic [3:0]  dec_alu_op;
  logic        dec_illegal;

  // In DECODE the live funct is checked; afterwards only the latched copy.
  assign dec_funct = (state_q == S_DECODE) ? funct : funct_q;

  alu_op_decode u_alu_op_decode (
    .funct_i   (dec_funct),
    .alu_op_o  (dec_alu_op),
    .illegal_o (dec_illegal)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dispatch(opcode);
        if (opcode == OP_RTYPE && dec_illegal) state_d = S_ILLEGAL;
      end
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register, instruction field latches and retired-instruction count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      if (state_q != S_FETCH && state_d == S_FETCH) count_q <= count_q + 32'd1;
    end
  end

  // Control outputs per state; anything not named stays 0.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_source  = PC_SRC_ALU;
    alu_op     = ALU_ADD;
    exception  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = SRC_B_IMM_SH;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_I_WB:      reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_SRC_ALU_OUT;
        pc_write  = (op_q == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
      end
      S_ILLEGAL:   exception = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Inputs change 2ns after each
// rising edge; outputs are sampled 1ns later, well clear of the edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_op, state;
  logic        exception;
  logic [31:0] instr_count;

  int n_total = 0;
  int n_pass  = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .exception(exception),
    .instr_count(instr_count)
  );

  // Clock: 10ns period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_total++; if (instr_count !== 32'd0) $display("FAIL reset_count got %0d want 0", instr_count); else n_pass++;
    n_total++; if (exception !== 1'b0) $display("FAIL reset_exc got %0b want 0", exception); else n_pass++;
    n_total++; if (mem_read !== 1'b1) $display("FAIL reset_mem_read got %0b want 1", mem_read); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    // One edge with reset low and mem_ready low: still FETCH.
  endtask

  task automatic test_lw();
    opcode = 6'h23; mem_ready = 1'b1; #1;
    n_total++; if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'd1)
      $display("FAIL lw_fetch state %0d ir %0b pc %0b srcb %0d want 0 1 1 1", state, ir_write, pc_write, alu_src_b); else n_pass++;
    tick();
    n_total++; if (state !== 4'd1 || alu_src_b !== 2'd3 || mem_read !== 1'b0)
      $display("FAIL lw_decode state %0d srcb %0d rd %0b want 1 3 0", state, alu_src_b, mem_read); else n_pass++;
    tick();
    n_total++; if (state !== 4'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd2)
      $display("FAIL lw_addr state %0d srca %0b srcb %0d want 2 1 2", state, alu_src_a, alu_src_b); else n_pass++;
    tick();
    n_total++; if (state !== 4'd3 || mem_read !== 1'b1 || i_or_d !== 1'b1)
      $display("FAIL lw_read state %0d rd %0b iod %0b want 3 1 1", state, mem_read, i_or_d); else n_pass++;
    tick();
    n_total++; if (state !== 4'd4 || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0)
      $display("FAIL lw_wb state %0d rw %0b m2r %0b dst %0b want 4 1 1 0", state, reg_write, mem_to_reg, reg_dst); else n_pass++;
    tick();
    n_total++; if (state !== 4'd0 || instr_count !== 32'd1)
      $display("FAIL lw_done state %0d count %0d want 0 1", state, instr_count); else n_pass++;
  endtask

  task automatic test_fetch_stall();
    mem_ready = 1'b0; opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0)
        $display("FAIL stall_%0d state %0d ir %0b pc %0b want 0 0 0", i, state, ir_write, pc_write); else n_pass++;
      tick();
    end
    mem_ready = 1'b1; #1;
    n_total++; if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1)
      $display("FAIL stall_release state %0d ir %0b pc %0b want 0 1 1", state, ir_write, pc_write); else n_pass++;
    tick(); tick();
    n_total++; if (state !== 4'd11 || pc_write !== 1'b1 || pc_source !== 2'd2)
      $display("FAIL jump state %0d pc %0b src %0d want 11 1 2", state, pc_write, pc_source); else n_pass++;
    tick();
    n_total++; if (state !== 4'd0 || instr_count !== 32'd2)
      $display("FAIL jump_done state %0d count %0d want 0 2", state, instr_count); else n_pass++;
  endtask

  task automatic test_branch();
    logic [5:0] ops [2];
    logic       exp_pc [2];
    ops[0] = 6'h04; exp_pc[0] = 1'b1;
    ops[1] = 6'h05; exp_pc[1] = 1'b0;
    zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i];
      tick(); tick();
      n_total++; if (state !== 4'd10 || pc_write !== exp_pc[i] || pc_source !== 2'd1 || alu_op !== 4'd1)
        $display("FAIL branch_%0d state %0d pc %0b src %0d op %0d want 10 %0b 1 1", i, state, pc_write, pc_source, alu_op, exp_pc[i]); else n_pass++;
      tick();
    end
    n_total++; if (instr_count !== 32'd4) $display("FAIL branch_count got %0d want 4", instr_count); else n_pass++;
  endtask

  task automatic test_rtype();
    opcode = 6'h00; funct = 6'h22;
    tick(); tick();
    funct = 6'h20; #1;
    n_total++; if (state !== 4'd6 || alu_op !== 4'd1 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0)
      $display("FAIL r_exec state %0d op %0d srca %0b srcb %0d want 6 1 1 0", state, alu_op, alu_src_a, alu_src_b); else n_pass++;
    tick();
    n_total++; if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0)
      $display("FAIL r_wb state %0d rw %0b dst %0b m2r %0b want 7 1 1 0", state, reg_write, reg_dst, mem_to_reg); else n_pass++;
    tick();
    n_total++; if (instr_count !== 32'd5) $display("FAIL r_count got %0d want 5", instr_count); else n_pass++;
  endtask

  task automatic test_sw_opcode_change();
    opcode = 6'h2B;
    tick(); tick();
    opcode = 6'h23;
    tick();
    mem_ready = 1'b0; #1;
    n_total++; if (state !== 4'd5 || mem_write !== 1'b1 || i_or_d !== 1'b1 || mem_read !== 1'b0)
      $display("FAIL sw_write state %0d wr %0b iod %0b rd %0b want 5 1 1 0", state, mem_write, i_or_d, mem_read); else n_pass++;
    tick();
    n_total++; if (state !== 4'd5) $display("FAIL sw_hold state %0d want 5", state); else n_pass++;
    mem_ready = 1'b1;
    tick();
    n_total++; if (state !== 4'd0 || instr_count !== 32'd6)
      $display("FAIL sw_done state %0d count %0d want 0 6", state, instr_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    n_total++; if (state !== 4'd3) $display("FAIL mid_read state %0d want 3", state); else n_pass++;
    reset = 1'b1; #1;
    n_total++; if (state !== 4'd0 || mem_read !== 1'b1 || instr_count !== 32'd0)
      $display("FAIL mid_reset state %0d rd %0b count %0d want 0 1 0", state, mem_read, instr_count); else n_pass++;
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h08;
    tick();
    n_total++; if (state !== 4'd1) $display("FAIL post_reset state %0d want 1", state); else n_pass++;
    tick();
    n_total++; if (state !== 4'd8 || alu_src_b !== 2'd2 || alu_src_a !== 1'b1)
      $display("FAIL addi_exec state %0d srcb %0d srca %0b want 8 2 1", state, alu_src_b, alu_src_a); else n_pass++;
    tick();
    n_total++; if (state !== 4'd9 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0)
      $display("FAIL addi_wb state %0d rw %0b dst %0b m2r %0b want 9 1 0 0", state, reg_write, reg_dst, mem_to_reg); else n_pass++;
    tick();
    n_total++; if (instr_count !== 32'd1) $display("FAIL addi_count got %0d want 1", instr_count); else n_pass++;
  endtask

  task automatic test_illegal();
    opcode = 6'h00; funct = 6'h3F;
    tick(); tick();
    opcode = 6'h02; funct = 6'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_total++; if (state !== 4'd12 || exception !== 1'b1 || pc_write !== 1'b0 || mem_read !== 1'b0 || reg_write !== 1'b0)
        $display("FAIL illegal_%0d state %0d exc %0b pc %0b rd %0b rw %0b want 12 1 0 0 0", i, state, exception, pc_write, mem_read, reg_write); else n_pass++;
      tick();
    end
    // Unknown opcode path, after clearing the exception with reset.
    reset = 1'b1; #1;
    n_total++; if (exception !== 1'b0 || state !== 4'd0)
      $display("FAIL illegal_clear exc %0b state %0d want 0 0", exception, state); else n_pass++;
    reset = 1'b0;
    opcode = 6'h3F;
    tick(); tick();
    n_total++; if (state !== 4'd12 || exception !== 1'b1)
      $display("FAIL bad_opcode state %0d exc %0b want 12 1", state, exception); else n_pass++;
  endtask

  initial begin
    mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_fetch_stall();
    test_branch();
    test_rtype();
    test_sw_opcode_change();
    test_reset_mid();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have inputs opcode[5:0], funct[5:0]: instruction-register fields from decode, valid from DECODE onward.
REQ-004 SHALL have input zero, 1: ALU zero flag, valid in BRANCH.
REQ-005 SHALL have input mem_ready, 1: memory completes the current access this cycle.
REQ-006 SHALL have outputs pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, each 1 bit.
REQ-007 SHALL have outputs alu_src_b[1:0] (0 reg, 1 const 4, 2 sign-ext imm, 3 imm<<2) and pc_source[1:0] (0 ALU result, 1 ALU out reg, 2 jump target).
REQ-008 SHALL have outputs alu_op[3:0] (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL), state[3:0], exception (1), instr_count[31:0].

Function
REQ-009 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL; state output = encoding 0..12 in that order.
REQ-010 SHALL, in FETCH, assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0; hold FETCH while mem_ready=0.
REQ-011 SHALL assert ir_write and pc_write combinationally only in the FETCH cycle where mem_ready=1, then go to DECODE.
REQ-012 SHALL, in DECODE, register opcode/funct into internal op_q/funct_q, drive alu_src_b=3, alu_op=ADD, and dispatch: 0x00 -> R_EXEC; 0x23/0x2B -> MEM_ADDR; 0x08 -> I_EXEC; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; any other -> ILLEGAL.
REQ-013 SHALL, for opcode 0x00, map funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL; any other funct in DECODE -> ILLEGAL.
REQ-014 SHALL make post-DECODE decisions from op_q/funct_q only, ignoring later opcode/funct changes.
REQ-015 SHALL drive MEM_ADDR with alu_src_a=1, alu_src_b=2, ADD; next MEM_READ if op_q=0x23 else MEM_WRITE.
REQ-016 SHALL, in MEM_READ/MEM_WRITE, assert mem_read/mem_write with i_or_d=1, holding state while mem_ready=0; MEM_READ -> MEM_WB, MEM_WRITE -> FETCH on mem_ready=1.
REQ-017 SHALL, in MEM_WB, assert reg_write, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 SHALL, in R_EXEC, drive alu_src_a=1, alu_src_b=0, alu_op per funct_q; R_WB asserts reg_write, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-019 SHALL, in I_EXEC, drive alu_src_a=1, alu_src_b=2, ADD; I_WB asserts reg_write, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-020 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=0, SUB, pc_source=1, pc_write = zero for 0x04, ~zero for 0x05; next FETCH.
REQ-021 SHALL, in JUMP, assert pc_write with pc_source=2; next FETCH.
REQ-022 SHALL, in ILLEGAL, hold exception=1, all write/strobe outputs 0, remain until reset.
REQ-023 SHALL deassert every output not listed for a state (0 value).
REQ-024 SHALL increment instr_count (mod 2^32, wraps) on each transition into FETCH from any non-FETCH state.
REQ-025 SHALL give latencies with mem_ready=1: lw 5, sw/R/addi 4, branch/jump 3 cycles.

Reset
REQ-026 SHALL, on reset assertion, immediately (asynchronously) enter FETCH, clear op_q, funct_q, instr_count, exception; mid-operation accesses are abandoned.
REQ-027 SHALL, on first edge after reset release, evaluate FETCH normally (no extra idle cycle).

Structure
REQ-028 SHALL place state encodings, opcode/funct constants, alu_op and mux-select encodings in shared package mips_ctrl_pkg.
REQ-029 SHALL split ALU-op decode into sub-module alu_op_decode (funct -> alu_op, illegal flag, combinational); FSM in this module.

Verification
REQ-030 lw (0x23), mem_ready=1 -> states 0,1,2,3,4,0; reg_write+mem_to_reg in cycle 5; instr_count 0->1.
REQ-031 FETCH with mem_ready low 3 cycles -> state stays 0, ir_write/pc_write 0, pulse once in cycle 4.
REQ-032 beq zero=1 then bne zero=1 -> pc_write=1 then 0 in BRANCH, pc_source=1.
REQ-033 R-type funct 0x22 -> alu_op=1 in R_EXEC; funct 0x3F -> ILLEGAL, exception=1 held 10 cycles.
REQ-034 opcode changed during MEM_ADDR from 0x2B to 0x23 -> still MEM_WRITE.
REQ-035 reset asserted during MEM_READ -> state=0, mem_read stays 1 (FETCH), instr_count=0 before next edge.
